// File: rtl/fetch_pipe_ctrl.sv
// fetch_pipe_ctrl: instruction-fetch stage controller.
//
// Owns the PC, the instruction-memory fetch handshake and the IF/ID pipeline
// register. Applies the hazard unit's stall / flush requests and freezes fetch
// once an HLT instruction is committed past IF/ID.
//
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-low reset
//   stall              load-to-use stall: hold PC and IF/ID
//   if_id_flush        branch taken in ID: kill IF/ID, redirect PC
//   branch_target      redirect address, valid with if_id_flush
//   imem_req/addr      fetch request at the current PC
//   imem_valid/rdata   fetched instruction, level-valid for imem_addr
//   if_id_instr        IF/ID instruction (also feeds hazard rs/rt decode)
//   if_id_pc_plus2     IF/ID PC+2
//   if_id_valid        IF/ID holds a real instruction
//   halt               processor halted (registered)
//   fetch_bubble_cnt   saturating count of bubbles caused by fetch

module fetch_pipe_ctrl #(
  parameter int unsigned     PC_W       = 16,
  parameter logic [PC_W-1:0] RESET_PC   = '0,
  parameter logic [3:0]      HLT_OPCODE = 4'hF,
  parameter int unsigned     CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             if_id_flush,
  input  logic [PC_W-1:0]  branch_target,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic             imem_valid,
  input  logic [15:0]      imem_rdata,
  output logic [15:0]      if_id_instr,
  output logic [PC_W-1:0]  if_id_pc_plus2,
  output logic             if_id_valid,
  output logic             halt,
  output logic [CNT_W-1:0] fetch_bubble_cnt
);

  localparam logic [1:0] StFetch     = 2'd0;
  localparam logic [1:0] StRedirWait = 2'd1;
  localparam logic [1:0] StHaltPend  = 2'd2;
  localparam logic [1:0] StHalted    = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [PC_W-1:0]  redir_pc_q, redir_pc_d;
  logic [15:0]      instr_q, instr_d;
  logic [PC_W-1:0]  pc_plus2_q, pc_plus2_d;
  logic             valid_q, valid_d;
  logic             halt_q, halt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [PC_W-1:0]  pc_inc;
  logic             bubble;
  logic             cnt_inc;
  logic             is_hlt;

  // Wraps modulo 2^PC_W by construction.
  assign pc_inc = pc_q + PC_W'(2);
  assign is_hlt = (imem_rdata[15:12] == HLT_OPCODE);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    redir_pc_d = redir_pc_q;
    instr_d    = instr_q;
    pc_plus2_d = pc_plus2_q;
    valid_d    = valid_q;
    bubble     = 1'b0;
    cnt_inc    = 1'b0;

    case (state_q)
      StFetch: begin
        if (if_id_flush) begin
          bubble = 1'b1;
          if (imem_valid) begin
            pc_d = branch_target;
          end else begin
            // PC may not move while a fetch is outstanding; park the target.
            redir_pc_d = branch_target;
            state_d    = StRedirWait;
          end
        end else if (!imem_valid) begin
          if (!stall) begin
            bubble  = 1'b1;
            cnt_inc = 1'b1;
          end
        end else if (!stall) begin
          instr_d    = imem_rdata;
          pc_plus2_d = pc_inc;
          valid_d    = 1'b1;
          if (is_hlt) begin
            state_d = StHaltPend;
          end else begin
            pc_d = pc_inc;
          end
        end
      end

      StRedirWait: begin
        // Stall is irrelevant here: IF/ID is forced to a bubble every cycle.
        bubble  = 1'b1;
        cnt_inc = 1'b1;
        if (if_id_flush) begin
          redir_pc_d = branch_target;
        end
        if (imem_valid) begin
          // Stale fetch data is dropped; newest redirect wins.
          pc_d    = if_id_flush ? branch_target : redir_pc_q;
          state_d = StFetch;
        end
      end

      StHaltPend: begin
        if (if_id_flush) begin
          // The HLT was on a mispredicted path.
          pc_d    = branch_target;
          bubble  = 1'b1;
          state_d = StFetch;
        end else if (!stall) begin
          bubble  = 1'b1;
          state_d = StHalted;
        end
      end

      StHalted: begin
        bubble = 1'b1;
      end

      default: begin
        state_d = StFetch;
      end
    endcase

    if (bubble) begin
      instr_d    = 16'h0000;
      pc_plus2_d = '0;
      valid_d    = 1'b0;
    end
  end

  // Saturate rather than wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign halt_d = (state_d == StHalted);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StFetch;
      pc_q       <= RESET_PC;
      redir_pc_q <= '0;
      instr_q    <= 16'h0000;
      pc_plus2_q <= '0;
      valid_q    <= 1'b0;
      halt_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      redir_pc_q <= redir_pc_d;
      instr_q    <= instr_d;
      pc_plus2_q <= pc_plus2_d;
      valid_q    <= valid_d;
      halt_q     <= halt_d;
      cnt_q      <= cnt_d;
    end
  end

  assign imem_req         = rst && ((state_q == StFetch) || (state_q == StRedirWait));
  assign imem_addr        = pc_q;
  assign if_id_instr      = instr_q;
  assign if_id_pc_plus2   = pc_plus2_q;
  assign if_id_valid      = valid_q;
  assign halt             = halt_q;
  assign fetch_bubble_cnt = cnt_q;

endmodule
